data_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 32x8 data memory between the CPU load/store path and the debug/loader port (switch-driven memory inspect and poke). It sequences each access through a three-state FSM against a synchronous RAM with 1-cycle read latency and returns data with a one-cycle acknowledge. Requesters that collide are served round-robin. A saturating conflict counter feeds the console display.

---
 rtl/data_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the CPU
// load/store path and the debug/loader port; one access per IDLE->ISSUE->CAPTURE pass.
module data_mem_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_busy_o,

    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              gnt_cpu_o,
    output logic              gnt_dbg_o,
    output logic [7:0]        conflict_cnt_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

    state_e              state_q;
    logic                mem_en_q, mem_we_q, op_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                cpu_ack_q, dbg_ack_q;
    logic [DATA_W-1:0]   cpu_rdata_q, dbg_rdata_q;
    logic                gnt_cpu_q, gnt_dbg_q;
    logic                last_cpu_q;
    logic [7:0]          conflict_cnt_q;

    logic cpu_eff, dbg_eff, win_cpu, contended;

    // A port is masked during its own ack so a still-high req is not re-granted.
    always_comb begin
        cpu_eff   = cpu_req_i & ~cpu_ack_q;
        dbg_eff   = dbg_req_i & ~dbg_ack_q;
        contended = cpu_eff & dbg_eff;
        win_cpu   = cpu_eff & (~dbg_eff | ~last_cpu_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            mem_en_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            op_we_q        <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            cpu_ack_q      <= 1'b0;
            dbg_ack_q      <= 1'b0;
            cpu_rdata_q    <= '0;
            dbg_rdata_q    <= '0;
            gnt_cpu_q      <= 1'b0;
            gnt_dbg_q      <= 1'b0;
            last_cpu_q     <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cpu_eff || dbg_eff) begin
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= win_cpu ? cpu_we_i    : dbg_we_i;
                        op_we_q     <= win_cpu ? cpu_we_i    : dbg_we_i;
                        mem_addr_q  <= win_cpu ? cpu_addr_i  : dbg_addr_i;
                        mem_wdata_q <= win_cpu ? cpu_wdata_i : dbg_wdata_i;
                        gnt_cpu_q   <= win_cpu;
                        gnt_dbg_q   <= ~win_cpu;
                        last_cpu_q  <= win_cpu;
                        state_q     <= StIssue;
                        if (contended && conflict_cnt_q != 8'hFF) begin
                            conflict_cnt_q <= conflict_cnt_q + 8'd1;
                        end
                    end
                end
                StIssue: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= StCapture;
                end
                StCapture: begin
                    if (gnt_cpu_q) begin
                        cpu_ack_q <= 1'b1;
                        if (!op_we_q) cpu_rdata_q <= mem_rdata_i;
                    end
                    if (gnt_dbg_q) begin
                        dbg_ack_q <= 1'b1;
                        if (!op_we_q) dbg_rdata_q <= mem_rdata_i;
                    end
                    gnt_cpu_q <= 1'b0;
                    gnt_dbg_q <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cpu_busy_o     = cpu_req_i & ~cpu_ack_q;
    assign cpu_ack_o      = cpu_ack_q;
    assign cpu_rdata_o    = cpu_rdata_q;
    assign dbg_ack_o      = dbg_ack_q;
    assign dbg_rdata_o    = dbg_rdata_q;
    assign mem_en_o       = mem_en_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign gnt_cpu_o      = gnt_cpu_q;
    assign gnt_dbg_o      = gnt_dbg_q;
    assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic against a
// transaction-timed reference model and a behavioural 32x8 synchronous RAM.
module tb_data_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [4:0] cpu_addr = '0, dbg_addr = '0;
    logic [7:0] cpu_wdata = '0, dbg_wdata = '0;
    logic       cpu_ack, cpu_busy, dbg_ack, mem_en, mem_we, gnt_cpu, gnt_dbg;
    logic [7:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata, conflict_cnt;
    logic [4:0] mem_addr;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    data_mem_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_req_i     (cpu_req),
        .cpu_we_i      (cpu_we),
        .cpu_addr_i    (cpu_addr),
        .cpu_wdata_i   (cpu_wdata),
        .cpu_ack_o     (cpu_ack),
        .cpu_rdata_o   (cpu_rdata),
        .cpu_busy_o    (cpu_busy),
        .dbg_req_i     (dbg_req),
        .dbg_we_i      (dbg_we),
        .dbg_addr_i    (dbg_addr),
        .dbg_wdata_i   (dbg_wdata),
        .dbg_ack_o     (dbg_ack),
        .dbg_rdata_o   (dbg_rdata),
        .mem_en_o      (mem_en),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .gnt_cpu_o     (gnt_cpu),
        .gnt_dbg_o     (gnt_dbg),
        .conflict_cnt_o(conflict_cnt)
    );

    // Synchronous RAM, 1-cycle read latency.
    logic [7:0] ram [32] = '{default: 8'h00};
    logic [7:0] ram_rd = 8'h00;
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_rd <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_rd;

    // Reference model: a granted access occupies two edges, the RAM effect lands on
    // the first, the ack on the second; decisions happen only when no access is open.
    logic [7:0] shadow [32] = '{default: 8'h00};
    int         m_timer = 0;
    logic       m_own_cpu = 1'b0, m_we = 1'b0, m_last_cpu = 1'b0;
    logic       m_cpu_ack = 1'b0, m_dbg_ack = 1'b0;
    logic [4:0] m_addr = '0;
    logic [7:0] m_wd = '0, m_rd = '0, m_cpu_rdata = '0, m_dbg_rdata = '0, m_cnt = '0;

    always @(posedge clock or posedge reset) begin : model
        logic ce, de;
        if (reset) begin
            m_timer = 0; m_own_cpu = 1'b0; m_last_cpu = 1'b0;
            m_cpu_ack = 1'b0; m_dbg_ack = 1'b0;
            m_cpu_rdata = '0; m_dbg_rdata = '0; m_cnt = '0;
        end else begin
            ce = cpu_req & ~m_cpu_ack;
            de = dbg_req & ~m_dbg_ack;
            m_cpu_ack = 1'b0;
            m_dbg_ack = 1'b0;
            if (m_timer == 2) begin
                m_timer = 1;
                if (m_we) shadow[m_addr] = m_wd;
                else      m_rd = shadow[m_addr];
            end else if (m_timer == 1) begin
                m_timer = 0;
                if (m_own_cpu) begin
                    m_cpu_ack = 1'b1;
                    if (!m_we) m_cpu_rdata = m_rd;
                end else begin
                    m_dbg_ack = 1'b1;
                    if (!m_we) m_dbg_rdata = m_rd;
                end
            end else if (ce || de) begin
                if (ce && de) begin
                    if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
                    m_own_cpu = ~m_last_cpu;
                end else begin
                    m_own_cpu = ce;
                end
                m_last_cpu = m_own_cpu;
                m_we   = m_own_cpu ? cpu_we    : dbg_we;
                m_addr = m_own_cpu ? cpu_addr  : dbg_addr;
                m_wd   = m_own_cpu ? cpu_wdata : dbg_wdata;
                m_timer = 2;
            end
        end
    end

    task automatic wait_ack(input logic is_dbg, output logic ok);
        int n = 0;
        while (((is_dbg ? dbg_ack : cpu_ack) !== 1'b1) && n < 8) begin
            @(posedge clock); #1;
            n++;
        end
        ok = ((is_dbg ? dbg_ack : cpu_ack) === 1'b1);
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic saw_ack = 1'b0;
        #2 reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata,
             gnt_cpu, gnt_dbg, conflict_cnt, cpu_busy} !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs=%h required 0", {mem_en, mem_we, mem_addr,
                     mem_wdata, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata, gnt_cpu, gnt_dbg,
                     conflict_cnt});
        end
        reset = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 8'h55;
        @(posedge clock); #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, gnt_dbg} !== {1'b1, 1'b1, 5'd3, 8'h55, 1'b1})
        begin
            errors++;
            $display("FAIL reset_issue_setup: en/we/addr/wd/gnt=%b/%b/%0d/%h/%b required 1/1/3/55/1",
                     mem_en, mem_we, mem_addr, mem_wdata, gnt_dbg);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata,
             gnt_cpu, gnt_dbg, conflict_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid_issue: mem_en=%b gnt_dbg=%b required all outputs 0",
                     mem_en, gnt_dbg);
        end
        dbg_req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
            if (dbg_ack !== 1'b0) saw_ack = 1'b1;
        end
        checks++;
        if (saw_ack) begin
            errors++;
            $display("FAIL reset_no_ack: dbg_ack seen 1 required 0");
        end
        checks++;
        if (ram[3] !== 8'h00) begin
            errors++;
            $display("FAIL reset_write_lost: ram[3]=%h required 00", ram[3]);
        end
    endtask

    task automatic test_cpu_load();
        logic ok;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd17; dbg_wdata = 8'hFF;
        wait_ack(1'b1, ok);
        dbg_req = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL load_preload_ack: timeout required dbg_ack"); end
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd17;
        @(posedge clock); #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, gnt_cpu, gnt_dbg, cpu_busy} !==
            {1'b1, 1'b0, 5'd17, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL load_grant: en/we/addr/gc/gd/busy=%b/%b/%0d/%b/%b/%b required 1/0/17/1/0/1",
                     mem_en, mem_we, mem_addr, gnt_cpu, gnt_dbg, cpu_busy);
        end
        @(posedge clock); #1;
        checks++;
        if ({mem_en, cpu_ack} !== 2'b00) begin
            errors++;
            $display("FAIL load_issue: mem_en=%b cpu_ack=%b required 0 0", mem_en, cpu_ack);
        end
        @(posedge clock); #1;
        checks++;
        if ({cpu_ack, cpu_rdata, cpu_busy} !== {1'b1, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL load_ack: ack=%b rdata=%h busy=%b required 1 ff 0",
                     cpu_ack, cpu_rdata, cpu_busy);
        end
        cpu_req = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL load_ack_width: cpu_ack=%b required 0", cpu_ack);
        end
    endtask

    task automatic test_write_read();
        logic ok;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd10; dbg_wdata = 8'h0A;
        wait_ack(1'b1, ok);
        dbg_req = 1'b0;
        checks++;
        if (!ok || dbg_rdata !== 8'h00) begin
            errors++;
            $display("FAIL wr_dbg_rdata: ack=%b dbg_rdata=%h required 1 00", ok, dbg_rdata);
        end
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd10;
        wait_ack(1'b0, ok);
        cpu_req = 1'b0;
        checks++;
        if (!ok || cpu_rdata !== 8'h0A) begin
            errors++;
            $display("FAIL wr_cpu_readback: ack=%b cpu_rdata=%h required 1 0a", ok, cpu_rdata);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_tie_alternate();
        logic exp_c, exp_d;
        pulse_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd2;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            exp_c = (k % 6) < 2;
            exp_d = (k % 6) == 3 || (k % 6) == 4;
            checks++;
            if ({gnt_cpu, gnt_dbg} !== {exp_c, exp_d}) begin
                errors++;
                $display("FAIL tie_grant_%0d: gnt_cpu/gnt_dbg=%b/%b required %b/%b",
                         k, gnt_cpu, gnt_dbg, exp_c, exp_d);
            end
        end
        checks++;
        if (conflict_cnt !== 8'd1) begin
            errors++;
            $display("FAIL tie_conflict: conflict_cnt=%0d required 1", conflict_cnt);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic test_hold();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            checks++;
            if ({gnt_cpu, mem_en, cpu_ack} !== {((k % 4) < 2), ((k % 4) == 0), ((k % 4) == 2)})
            begin
                errors++;
                $display("FAIL hold_%0d: gnt/en/ack=%b/%b/%b required %b/%b/%b", k, gnt_cpu,
                         mem_en, cpu_ack, (k % 4) < 2, (k % 4) == 0, (k % 4) == 2);
            end
        end
        cpu_req = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic test_saturate();
        logic ok_c, ok_d;
        int timeouts = 0;
        pulse_reset();
        cpu_we = 1'b0; dbg_we = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cpu_req = 1'b1; dbg_req = 1'b1;
            wait_ack(1'b0, ok_c);
            cpu_req = 1'b0;
            wait_ack(1'b1, ok_d);
            dbg_req = 1'b0;
            if (!ok_c || !ok_d) timeouts++;
            @(posedge clock); #1;
            if (i == 253 || i == 254) begin
                checks++;
                if (conflict_cnt !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL sat_count_%0d: conflict_cnt=%0d required %0d",
                             i, conflict_cnt, i + 1);
                end
            end
        end
        checks++;
        if (timeouts != 0) begin
            errors++;
            $display("FAIL sat_timeouts: %0d ack timeouts required 0", timeouts);
        end
        checks++;
        if (conflict_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_final: conflict_cnt=%0d required 255", conflict_cnt);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        pulse_reset();
        for (int k = 0; k < 400; k++) begin
            if (!cpu_req || (cpu_ack && $urandom_range(1, 0) == 0)) begin
                cpu_req = cpu_req ? 1'b0 : ($urandom_range(2, 0) == 0);
                cpu_we = 1'($urandom); cpu_addr = 5'($urandom); cpu_wdata = 8'($urandom);
            end else if (cpu_ack) begin
                cpu_we = 1'($urandom); cpu_addr = 5'($urandom); cpu_wdata = 8'($urandom);
            end
            if (!dbg_req || (dbg_ack && $urandom_range(1, 0) == 0)) begin
                dbg_req = dbg_req ? 1'b0 : ($urandom_range(2, 0) == 0);
                dbg_we = 1'($urandom); dbg_addr = 5'($urandom); dbg_wdata = 8'($urandom);
            end else if (dbg_ack) begin
                dbg_we = 1'($urandom); dbg_addr = 5'($urandom); dbg_wdata = 8'($urandom);
            end
            @(posedge clock); #1;
            checks++;
            if ({cpu_ack, dbg_ack, gnt_cpu, gnt_dbg, mem_en} !==
                {m_cpu_ack, m_dbg_ack, m_timer != 0 && m_own_cpu, m_timer != 0 && !m_own_cpu,
                 m_timer == 2}) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_ctrl_%0d: ack c/d=%b/%b gnt c/d=%b/%b en=%b required %b/%b %b/%b %b",
                    k, cpu_ack, dbg_ack, gnt_cpu, gnt_dbg, mem_en, m_cpu_ack, m_dbg_ack,
                    m_timer != 0 && m_own_cpu, m_timer != 0 && !m_own_cpu, m_timer == 2);
            end
            checks++;
            if ({cpu_rdata, dbg_rdata, conflict_cnt} !== {m_cpu_rdata, m_dbg_rdata, m_cnt}) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_data_%0d: rdata c/d=%h/%h cnt=%0d required %h/%h %0d",
                    k, cpu_rdata, dbg_rdata, conflict_cnt, m_cpu_rdata, m_dbg_rdata, m_cnt);
            end
            checks++;
            if (cpu_busy !== (cpu_req & ~m_cpu_ack)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_busy_%0d: cpu_busy=%b required %b",
                    k, cpu_busy, cpu_req & ~m_cpu_ack);
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cpu_load();
        test_write_read();
        test_tie_alternate();
        test_hold();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached required completion");
        $fatal(1);
    end

endmodule
